cbfp_norm: RTL and testbench

Parametrised convergent block-floating-point (CBFP) normaliser for the pipelined FFT datapath. It accepts LANES complex samples per beat from a butterfly sub-stage and accumulates each group of GROUP_LEN samples in a ping-pong buffer. Once a group is complete it finds the group's minimum redundant-sign-bit count, left-shifts every sample of the group by that count and truncates to O_WIDTH. It emits the shift count as the group exponent index and accepts continuous back-to-back groups with no backpressure.

---
 rtl/cbfp_norm.sv | 208 ++++++++++++++++++++
 tb/tb_cbfp_norm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cbfp_norm.sv
// cbfp_norm: convergent block-floating-point normaliser, ping-pong buffered, one beat per cycle.
// Define CBFP_ROUND_EN for round-half-up with saturation (adds one output register stage).
module cbfp_norm #(
    parameter int I_WIDTH   = 22,
    parameter int O_WIDTH   = 11,
    parameter int LANES     = 16,
    parameter int GROUP_LEN = 64,
    parameter int IDX_WIDTH = 5
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              valid_i,
    input  logic [LANES-1:0][I_WIDTH-1:0]     din_re_i,
    input  logic [LANES-1:0][I_WIDTH-1:0]     din_im_i,
    output logic [LANES-1:0][O_WIDTH-1:0]     dout_re_o,
    output logic [LANES-1:0][O_WIDTH-1:0]     dout_im_o,
    output logic [IDX_WIDTH-1:0]              idx_o,
    output logic                              valid_o,
    output logic                              sof_o
);
    localparam int BEATS = GROUP_LEN / LANES;
    localparam int BW    = $clog2(BEATS);
    localparam int SH    = I_WIDTH - O_WIDTH;

    typedef enum logic {R_IDLE, R_OUT} rstate_t;

    function automatic logic [IDX_WIDTH-1:0] rsb_f(input logic [I_WIDTH-1:0] x);
        logic [IDX_WIDTH-1:0] n;
        logic                 run;
        n   = '0;
        run = 1'b1;
        for (int k = I_WIDTH-2; k >= 0; k--) begin
            run = run & (x[k] == x[I_WIDTH-1]);
            n   = n + IDX_WIDTH'(run);
        end
        return n;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] min_f(input logic [IDX_WIDTH-1:0] a, input logic [IDX_WIDTH-1:0] b);
        return a < b ? a : b;
    endfunction

    function automatic logic [O_WIDTH-1:0] norm_f(input logic [I_WIDTH-1:0] x, input logic [IDX_WIDTH-1:0] s);
        logic signed [I_WIDTH-1:0] sh;
`ifdef CBFP_ROUND_EN
        logic signed [I_WIDTH:0]   r;
        logic signed [O_WIDTH:0]   q;
`endif
        sh = $signed(x) <<< s;
`ifdef CBFP_ROUND_EN
        r = {sh[I_WIDTH-1], sh} + ((I_WIDTH+1)'(1) << (SH-1));
        q = (O_WIDTH+1)'(r >>> SH);
        // only positive overflow is reachable since the rounding offset is positive
        return q[O_WIDTH] != q[O_WIDTH-1] ? {1'b0, {(O_WIDTH-1){1'b1}}} : q[O_WIDTH-1:0];
`else
        return O_WIDTH'(sh >>> SH);
`endif
    endfunction

    logic [LANES-1:0][I_WIDTH-1:0] mem_re_q [2][BEATS];
    logic [LANES-1:0][I_WIDTH-1:0] mem_im_q [2][BEATS];

    logic [BW-1:0]                 wcnt_q, wcnt_d;
    logic                          wbank_q, wbank_d;
    logic [IDX_WIDTH-1:0]          gmin_q, gmin_d, bmin, gnew;
    logic [1:0][IDX_WIDTH-1:0]     grp_idx_q, grp_idx_d;
    logic [1:0]                    req_q, req_d;
    logic                          wlast, take, nbank, rlast;

    rstate_t                       state_q, state_d;
    logic                          rbank_q, rbank_d;
    logic [BW-1:0]                 rcnt_q, rcnt_d;

    logic                          rd_v, rd_sof, o_v, o_sof;
    logic [IDX_WIDTH-1:0]          rd_idx, o_idx, idx_q, idx_d;
    logic [LANES-1:0][I_WIDTH-1:0] rd_re, rd_im, o_re, o_im;
    logic [LANES-1:0][O_WIDTH-1:0] dout_re_q, dout_re_d, dout_im_q, dout_im_d;
    logic                          valid_q, sof_q;

    always_comb begin
        bmin = IDX_WIDTH'(I_WIDTH-1);
        for (int l = 0; l < LANES; l++)
            bmin = min_f(bmin, min_f(rsb_f(din_re_i[l]), rsb_f(din_im_i[l])));
    end

    always_comb begin
        wlast     = valid_i && wcnt_q == BW'(BEATS-1);
        gnew      = (wcnt_q == '0 || bmin < gmin_q) ? bmin : gmin_q;
        wcnt_d    = valid_i ? (wlast ? '0 : wcnt_q + 1'b1) : wcnt_q;
        wbank_d   = wbank_q ^ wlast;
        gmin_d    = valid_i ? gnew : gmin_q;
        grp_idx_d = grp_idx_q;
        req_d     = req_q;
        if (wlast) grp_idx_d[wbank_q] = gnew;
        if (take) req_d[nbank] = 1'b0;
        if (wlast) req_d[wbank_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            mem_re_q[wbank_q][wcnt_q] <= din_re_i;
            mem_im_q[wbank_q][wcnt_q] <= din_im_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wcnt_q    <= '0;
            wbank_q   <= 1'b0;
            gmin_q    <= '0;
            grp_idx_q <= '0;
            req_q     <= '0;
        end else begin
            wcnt_q    <= wcnt_d;
            wbank_q   <= wbank_d;
            gmin_q    <= gmin_d;
            grp_idx_q <= grp_idx_d;
            req_q     <= req_d;
        end
    end

    // banks are consumed in write order, so the next bank to read is always the other one;
    // rbank resets to 1 so that the first group (bank 0) is next
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= R_IDLE;
            rbank_q <= 1'b1;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        nbank   = ~rbank_q;
        rlast   = rcnt_q == BW'(BEATS-1);
        take    = req_q[nbank] && (state_q == R_IDLE || rlast);
        state_d = take ? R_OUT : ((state_q == R_OUT && !rlast) ? R_OUT : R_IDLE);
        rbank_d = take ? nbank : rbank_q;
        rcnt_d  = (state_q == R_OUT && !rlast) ? rcnt_q + 1'b1 : '0;
    end

    always_comb begin
        rd_v   = state_q == R_OUT;
        rd_sof = rd_v && rcnt_q == '0;
        rd_idx = grp_idx_q[rbank_q];
        rd_re  = mem_re_q[rbank_q][rcnt_q];
        rd_im  = mem_im_q[rbank_q][rcnt_q];
    end

`ifdef CBFP_ROUND_EN
    logic                          s_v_q, s_sof_q;
    logic [IDX_WIDTH-1:0]          s_idx_q;
    logic [LANES-1:0][I_WIDTH-1:0] s_re_q, s_im_q;

    always_ff @(posedge clk_i) begin
        s_v_q   <= rstn_i && rd_v;
        s_sof_q <= rstn_i && rd_sof;
        s_idx_q <= rd_idx;
        s_re_q  <= rd_re;
        s_im_q  <= rd_im;
    end

    assign o_v   = s_v_q;
    assign o_sof = s_sof_q;
    assign o_idx = s_idx_q;
    assign o_re  = s_re_q;
    assign o_im  = s_im_q;
`else
    assign o_v   = rd_v;
    assign o_sof = rd_sof;
    assign o_idx = rd_idx;
    assign o_re  = rd_re;
    assign o_im  = rd_im;
`endif

    always_comb begin
        idx_d = o_sof ? o_idx : idx_q;
        for (int l = 0; l < LANES; l++) begin
            dout_re_d[l] = o_v ? norm_f(o_re[l], o_idx) : '0;
            dout_im_d[l] = o_v ? norm_f(o_im[l], o_idx) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dout_re_q <= '0;
            dout_im_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
        end else begin
            dout_re_q <= dout_re_d;
            dout_im_q <= dout_im_d;
            idx_q     <= idx_d;
            valid_q   <= o_v;
            sof_q     <= o_sof;
        end
    end

    assign dout_re_o = dout_re_q;
    assign dout_im_o = dout_im_q;
    assign idx_o     = idx_q;
    assign valid_o   = valid_q;
    assign sof_o     = sof_q;
endmodule

// File: tb/tb_cbfp_norm.sv
// tb_cbfp_norm: directed checks of cbfp_norm at default parameters (BEATS = 4).
module tb_cbfp_norm;
    localparam int I_W = 22;
    localparam int O_W = 11;
    localparam int L   = 16;
    localparam int IW  = 5;
`ifdef CBFP_ROUND_EN
    localparam int LAT = 3;
    localparam int RND = 256;
`else
    localparam int LAT = 2;
    localparam int RND = 255;
`endif

    logic                    clk = 1'b0;
    logic                    rstn, valid, vout, sof;
    logic [L-1:0][I_W-1:0]   din_re, din_im;
    logic [L-1:0][O_W-1:0]   dout_re, dout_im;
    logic [IW-1:0]           idx;
    int                      n_chk = 0;
    int                      n_fail = 0;

    always #5 clk = ~clk;

    cbfp_norm dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .valid_i   (valid),
        .din_re_i  (din_re),
        .din_im_i  (din_im),
        .dout_re_o (dout_re),
        .dout_im_o (dout_im),
        .idx_o     (idx),
        .valid_o   (vout),
        .sof_o     (sof)
    );

    task automatic chk(input string tag, input logic [L*O_W-1:0] obs, input logic [L*O_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input int a, input int b);
        @(negedge clk);
        valid = v;
        for (int l = 0; l < L; l++) begin
            din_re[l] = I_W'(a);
            din_im[l] = I_W'(a);
        end
        din_re[0] = I_W'(b);
    endtask

    // b replaces lane 0 re of the first valid beat only
    task automatic send(input int n, input logic [7:0] pat, input int a, input int b);
        logic done;
        done = 1'b0;
        for (int i = 0; i < n; i++) begin
            beat(pat[i], a, (pat[i] && !done) ? b : a);
            done = done | pat[i];
        end
    endtask

    task automatic ogroup(input string tag, input int ix, input int e0, input int eo, input bit first);
        logic [L-1:0][O_W-1:0] er, ei;
        if (first) begin
            repeat (LAT) @(negedge clk);
            chk({tag, " early"}, vout, 0);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            for (int l = 0; l < L; l++) begin
                er[l] = O_W'(eo);
                ei[l] = O_W'(eo);
            end
            if (b == 0) er[0] = O_W'(e0);
            chk($sformatf("%s b%0d valid", tag, b), vout, 1);
            chk($sformatf("%s b%0d sof", tag, b), sof, b == 0);
            chk($sformatf("%s b%0d idx", tag, b), idx, ix);
            chk($sformatf("%s b%0d re", tag, b), dout_re, er);
            chk($sformatf("%s b%0d im", tag, b), dout_im, ei);
        end
    endtask

    task automatic group(input string tag, input int n, input logic [7:0] pat, input int a, input int b,
                         input int ix, input int e0, input int eo);
        fork
            begin
                send(n, pat, a, b);
                beat(0, 0, 0);
            end
            begin
                repeat (n) @(negedge clk);
                ogroup(tag, ix, e0, eo, 1);
            end
        join
    endtask

    initial begin
        rstn   = 1'b0;
        valid  = 1'b0;
        din_re = '0;
        din_im = '0;
        repeat (3) @(negedge clk);
        chk("rst valid", vout, 0);
        chk("rst sof", sof, 0);
        chk("rst idx", idx, 0);
        chk("rst re", dout_re, 0);
        chk("rst im", dout_im, 0);
        rstn = 1'b1;

        group("ones", 4, 8'h0f, 1, 1, 20, 512, 512);
        group("fsneg", 4, 8'h0f, 1, -2097152, 0, -1024, 0);
        group("zero", 4, 8'h0f, 0, 0, 21, 0, 0);
        group("round", 4, 8'h0f, 1023, 3000, 9, 750, RND);
        group("sat", 4, 8'h0f, 2097151, 2097151, 0, 1023, 1023);
        group("gaps", 7, 8'h59, 1, 1, 20, 512, 512);

        fork
            begin
                send(4, 8'h0f, 1, 1);
                send(4, 8'h0f, 1000, 1000);
                send(4, 8'h0f, 0, 0);
                beat(0, 0, 0);
            end
            begin
                repeat (4) @(negedge clk);
                ogroup("b2b0", 20, 512, 512, 1);
                ogroup("b2b1", 11, 1000, 1000, 0);
                ogroup("b2b2", 21, 0, 0, 0);
                @(negedge clk);
                chk("b2b end", vout, 0);
            end
        join

        beat(1, 5, 5);
        beat(1, 5, 5);
        @(negedge clk);
        rstn  = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("midrst valid", vout, 0);
        rstn = 1'b1;
        group("fresh", 4, 8'h0f, 1, 1, 20, 512, 512);

        fork
            begin
                send(4, 8'h0f, 1, 1);
                beat(0, 0, 0);
            end
            begin
                repeat (4 + LAT + 2) @(negedge clk);
                chk("abort pre", vout, 1);
                rstn = 1'b0;
                @(negedge clk);
                chk("abort valid", vout, 0);
                rstn = 1'b1;
                repeat (6) @(negedge clk);
                chk("abort tail", vout, 0);
            end
        join

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
